xor_stream_cipher: RTL and testbench

Parametrised successor to the single-key serial XOR datapath. It loads up to KEY_SLOTS keys serially into a key bank, deserialises one MSG_SIZE-bit message, and encrypts it chunk by chunk. Encryption uses either a repeating key or a rolling, rotated key. The ciphertext is serialised out with a data-valid flag, and done and error strobes are provided. It sits between the pad-level serial inputs and the output pins of the chip top.

---
 rtl/xor_stream_cipher_if.sv | 29 ++
 rtl/xor_stream_cipher.sv | 176 +++++++++++++++++
 tb/tb_xor_stream_cipher.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/xor_stream_cipher_if.sv
// Signal bundle between the pad-level serial inputs, the cipher core and the chip outputs.
// The master side drives enable, serial data and load strobes; the slave (cipher) drives status and ciphertext.
interface xor_stream_cipher_if #(
    parameter int KEY_SLOTS = 4,
    parameter int SEL_W     = $clog2(KEY_SLOTS)
);
    logic                 ena;
    logic                 iData_in;
    logic                 iKey_flag;
    logic                 iMsg_flag;
    logic [SEL_W-1:0]     iKey_sel;
    logic                 iMode;
    logic                 oData_out;
    logic                 oData_flag;
    logic                 oBusy;
    logic                 oDone;
    logic                 oError;
    logic [KEY_SLOTS-1:0] oKey_valid;

    modport master (
        output ena, iData_in, iKey_flag, iMsg_flag, iKey_sel, iMode,
        input  oData_out, oData_flag, oBusy, oDone, oError, oKey_valid
    );

    modport slave (
        input  ena, iData_in, iKey_flag, iMsg_flag, iKey_sel, iMode,
        output oData_out, oData_flag, oBusy, oDone, oError, oKey_valid
    );
endinterface

// File: rtl/xor_stream_cipher.sv
// Serial XOR stream cipher with a multi-slot key bank.
// Keys and the message arrive serially MSB first.
// The message is encrypted one key-sized chunk per cycle with either a repeating key or a rolling, rotated key.
// The ciphertext is then shifted out MSB first with a valid flag.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | accept key / message bits; message completion starts a run
// ENCRYPT | one chunk per cycle, msg chunk XOR (rotated) slot key
// SHIFT   | ciphertext streamed out MSB first, oData_flag high
// DONE    | oDone pulse, back to IDLE
module xor_stream_cipher #(
    parameter int MSG_SIZE  = 64,
    parameter int KEY_SIZE  = 8,
    parameter int KEY_SLOTS = 4,
    parameter int SEL_W     = $clog2(KEY_SLOTS)
) (
    input  logic               clk,
    input  logic               rst,
    xor_stream_cipher_if.slave bus
);
    localparam int N_CHUNK = MSG_SIZE / KEY_SIZE;
    localparam int KCW     = $clog2(KEY_SIZE) + 1;
    localparam int MCW     = $clog2(MSG_SIZE) + 1;
    localparam int CIW     = $clog2(N_CHUNK) + 1;

    localparam logic [KCW-1:0] KEY_LAST   = KCW'(KEY_SIZE - 1);
    localparam logic [MCW-1:0] MSG_LAST   = MCW'(MSG_SIZE - 1);
    localparam logic [CIW-1:0] CHUNK_LAST = CIW'(N_CHUNK - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ENCRYPT = 2'd1,
        SHIFT   = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t               state;
    logic [KEY_SIZE-1:0]  key_slot [KEY_SLOTS];
    logic [KEY_SLOTS-1:0] key_valid;
    logic [KCW-1:0]       key_cnt;
    logic [MCW-1:0]       msg_cnt;
    logic [MCW-1:0]       shift_cnt;
    logic [CIW-1:0]       chunk_idx;
    logic [MSG_SIZE-1:0]  msg_reg;
    logic [MSG_SIZE-1:0]  cipher;
    logic [SEL_W-1:0]     sel_r;
    logic                 mode_r;
    logic                 data_out_r;
    logic                 data_flag_r;
    logic                 busy_r;
    logic                 done_r;
    logic                 error_r;

    logic [KEY_SIZE-1:0]  key_cur;
    logic [KEY_SIZE-1:0]  key_use;
    logic [KEY_SIZE-1:0]  chunk_ct;
    int unsigned          rot_amt;

    // Rotate left by taking the upper half of the doubled word after shifting.
    function automatic logic [KEY_SIZE-1:0] rotl(input logic [KEY_SIZE-1:0] v, input int unsigned amt);
        logic [2*KEY_SIZE-1:0] d;
        d = {v, v} << amt;
        return d[2*KEY_SIZE-1 -: KEY_SIZE];
    endfunction

    // Current ciphertext chunk: top chunk of the rotating message register XOR the selected key.
    always_comb begin
        rot_amt  = int'(chunk_idx) % KEY_SIZE;
        key_cur  = key_slot[sel_r];
        key_use  = mode_r ? rotl(key_cur, rot_amt) : key_cur;
        chunk_ct = msg_reg[MSG_SIZE-1 -: KEY_SIZE] ^ key_use;
    end

    // Key bank, message deserialiser, sequencing FSM and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            for (int s = 0; s < KEY_SLOTS; s++) key_slot[s] <= '0;
            key_valid   <= '0;
            key_cnt     <= '0;
            msg_cnt     <= '0;
            shift_cnt   <= '0;
            chunk_idx   <= '0;
            msg_reg     <= '0;
            cipher      <= '0;
            sel_r       <= '0;
            mode_r      <= 1'b0;
            data_out_r  <= 1'b0;
            data_flag_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            error_r     <= 1'b0;
        end else if (bus.ena) begin
            done_r  <= 1'b0;
            error_r <= 1'b0;
            case (state)
                IDLE: begin
                    data_out_r  <= 1'b0;
                    data_flag_r <= 1'b0;
                    if (bus.iKey_flag) begin
                        // Key load has priority; a concurrent message bit is dropped and msg_cnt holds.
                        key_slot[bus.iKey_sel] <= {key_slot[bus.iKey_sel][KEY_SIZE-2:0], bus.iData_in};
                        if (key_cnt == KEY_LAST) begin
                            key_valid[bus.iKey_sel] <= 1'b1;
                            key_cnt                 <= '0;
                        end else begin
                            key_cnt <= key_cnt + KCW'(1);
                        end
                    end else begin
                        // A key strobe that ends part-way leaves the slot unusable.
                        if (key_cnt != '0) begin
                            key_cnt                 <= '0;
                            key_valid[bus.iKey_sel] <= 1'b0;
                        end
                        if (bus.iMsg_flag) begin
                            msg_reg <= {msg_reg[MSG_SIZE-2:0], bus.iData_in};
                            if (msg_cnt == MSG_LAST) begin
                                msg_cnt <= '0;
                                sel_r   <= bus.iKey_sel;
                                mode_r  <= bus.iMode;
                                if (key_valid[bus.iKey_sel]) begin
                                    state     <= ENCRYPT;
                                    busy_r    <= 1'b1;
                                    chunk_idx <= '0;
                                end else begin
                                    error_r <= 1'b1;
                                end
                            end else begin
                                msg_cnt <= msg_cnt + MCW'(1);
                            end
                        end else begin
                            msg_cnt <= '0;
                        end
                    end
                end
                ENCRYPT: begin
                    // msg_reg rotates by a chunk so it is back in its original order after N cycles.
                    cipher  <= (cipher << KEY_SIZE) | MSG_SIZE'(chunk_ct);
                    msg_reg <= (msg_reg << KEY_SIZE) | (msg_reg >> (MSG_SIZE - KEY_SIZE));
                    if (chunk_idx == CHUNK_LAST) begin
                        state     <= SHIFT;
                        shift_cnt <= '0;
                    end else begin
                        chunk_idx <= chunk_idx + CIW'(1);
                    end
                end
                SHIFT: begin
                    data_flag_r <= 1'b1;
                    data_out_r  <= cipher[MSG_SIZE-1];
                    cipher      <= cipher << 1;
                    if (shift_cnt == MSG_LAST) begin
                        state  <= DONE;
                        busy_r <= 1'b0;
                    end else begin
                        shift_cnt <= shift_cnt + MCW'(1);
                    end
                end
                DONE: begin
                    data_out_r  <= 1'b0;
                    data_flag_r <= 1'b0;
                    done_r      <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.oData_out  = data_out_r;
    assign bus.oData_flag = data_flag_r;
    assign bus.oBusy      = busy_r;
    assign bus.oDone      = done_r;
    assign bus.oError     = error_r;
    assign bus.oKey_valid = key_valid;
endmodule

// File: tb/tb_xor_stream_cipher.sv
// Directed bench for xor_stream_cipher: key loads, both cipher modes, error path,
// partial key abort, simultaneous strobes, enable freeze and asynchronous reset.
module tb_xor_stream_cipher;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_err;

    xor_stream_cipher_if #(.KEY_SLOTS(4)) bus ();

    xor_stream_cipher #(
        .MSG_SIZE (64),
        .KEY_SIZE (8),
        .KEY_SLOTS(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic send_key(input int slot, input logic [7:0] val, input int nbits);
        bus.iKey_sel  = 2'(slot);
        bus.iKey_flag = 1'b1;
        for (int b = 0; b < nbits; b++) begin
            bus.iData_in = val[7-b];
            tick();
        end
        bus.iKey_flag = 1'b0;
        bus.iData_in  = 1'b0;
        tick();
    endtask

    // Leaves the bench just after the edge that samples the last message bit.
    task automatic send_msg(input int sel, input logic mode, input logic [63:0] val);
        bus.iKey_sel  = 2'(sel);
        bus.iMode     = mode;
        bus.iMsg_flag = 1'b1;
        for (int b = 0; b < 64; b++) begin
            bus.iData_in = val[63-b];
            tick();
        end
        bus.iMsg_flag = 1'b0;
        bus.iData_in  = 1'b0;
    endtask

    // Collects the serial ciphertext; pause_at >= 0 freezes ena for 10 cycles before that bit.
    task automatic receive(input string tag, input logic [63:0] exp, input int pause_at);
        int          lat;
        logic        flag_ok;
        logic [63:0] got;
        got     = '0;
        flag_ok = 1'b1;
        check({tag, "_busy"}, bus.oBusy, 1'b1);
        lat = 0;
        while (bus.oData_flag !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, lat, 9);
        for (int i = 0; i < 64; i++) begin
            if (i == pause_at) begin
                bus.ena = 1'b0;
                repeat (10) tick();
                check({tag, "_hold_out"}, bus.oData_out, exp[63-i]);
                check({tag, "_hold_flag"}, bus.oData_flag, 1'b1);
                bus.ena = 1'b1;
            end
            got[63-i] = bus.oData_out;
            if (bus.oData_flag !== 1'b1) flag_ok = 1'b0;
            tick();
        end
        check({tag, "_cipher"}, got, exp);
        check({tag, "_flag_run"}, flag_ok, 1'b1);
        check({tag, "_flag_drop"}, bus.oData_flag, 1'b0);
        check({tag, "_done"}, bus.oDone, 1'b1);
        tick();
        check({tag, "_done_clr"}, bus.oDone, 1'b0);
        check({tag, "_busy_clr"}, bus.oBusy, 1'b0);
    endtask

    initial begin
        n_checks      = 0;
        n_err         = 0;
        rst           = 1'b1;
        bus.ena       = 1'b1;
        bus.iData_in  = 1'b0;
        bus.iKey_flag = 1'b0;
        bus.iMsg_flag = 1'b0;
        bus.iKey_sel  = '0;
        bus.iMode     = 1'b0;
        repeat (2) tick();
        check("rst_outputs", {bus.oData_out, bus.oData_flag, bus.oBusy, bus.oDone, bus.oError}, 5'b0);
        check("rst_key_valid", bus.oKey_valid, 4'b0000);
        rst = 1'b0;
        tick();

        // Repeating key, slot 0 = 0xAC.
        send_key(0, 8'hAC, 8);
        check("key0_valid", bus.oKey_valid, 4'b0001);
        send_msg(0, 1'b0, 64'h0123456789ABCDEF);
        receive("mode0", 64'hAD8FE9CB25076143, -1);

        // Rolling key, slot 2 = 0x81, zero message exposes the rotated key stream.
        send_key(2, 8'h81, 8);
        check("key2_valid", bus.oKey_valid, 4'b0101);
        send_msg(2, 1'b1, 64'h0);
        receive("mode1", 64'h8103060C183060C0, -1);

        // Message against an empty slot.
        send_msg(3, 1'b0, 64'hFFFF0000FFFF0000);
        check("err_pulse", bus.oError, 1'b1);
        check("err_flag", bus.oData_flag, 1'b0);
        check("err_busy", bus.oBusy, 1'b0);
        tick();
        check("err_clr", bus.oError, 1'b0);
        repeat (12) tick();
        check("err_idle_flag", {bus.oData_flag, bus.oBusy, bus.oDone}, 3'b000);

        // Partial key load into slot 1 is discarded.
        send_key(1, 8'hF0, 5);
        check("partial_valid", bus.oKey_valid, 4'b0101);
        check("partial_key_cnt", dut.key_cnt, 0);
        send_key(1, 8'h33, 8);
        check("full_valid", bus.oKey_valid, 4'b0111);

        // Key load interleaved into a message load, plus an enable freeze mid-stream.
        bus.iKey_sel  = 2'd1;
        bus.iMode     = 1'b0;
        bus.iMsg_flag = 1'b1;
        begin
            logic [63:0] m;
            logic [7:0]  k;
            m = 64'h0123456789ABCDEF;
            k = 8'h5A;
            for (int b = 0; b < 10; b++) begin
                bus.iData_in = m[63-b];
                tick();
            end
            bus.iKey_flag = 1'b1;
            for (int b = 0; b < 8; b++) begin
                bus.iData_in = k[7-b];
                tick();
            end
            bus.iKey_flag = 1'b0;
            check("both_msg_cnt", dut.msg_cnt, 10);
            check("both_key_cnt", dut.key_cnt, 0);
            for (int b = 10; b < 64; b++) begin
                bus.iData_in = m[63-b];
                tick();
            end
            bus.iMsg_flag = 1'b0;
            bus.iData_in  = 1'b0;
        end
        receive("both_ena", 64'h5B791F3DD3F197B5, 20);

        // Asynchronous reset while streaming.
        send_msg(0, 1'b0, 64'h0123456789ABCDEF);
        begin
            int guard;
            guard = 0;
            while (bus.oData_flag !== 1'b1 && guard < 40) begin
                tick();
                guard++;
            end
            check("rst_reach_shift", bus.oData_flag, 1'b1);
        end
        repeat (5) tick();
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_outputs", {bus.oData_out, bus.oData_flag, bus.oBusy, bus.oDone, bus.oError}, 5'b0);
        check("async_rst_valid", bus.oKey_valid, 4'b0000);
        tick();
        rst = 1'b0;
        tick();
        send_key(3, 8'hFF, 8);
        check("post_rst_valid", bus.oKey_valid, 4'b1000);
        send_msg(3, 1'b0, 64'h0123456789ABCDEF);
        receive("post_rst", 64'hFEDCBA9876543210, -1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
